// File: rtl/riscv151_lsu.sv
// Riscv151 load/store unit: one request at a time, issued as one or two aligned dcache beats.
// Build option: define RISCV151_LSU_MISALIGN_SPLIT_EN to service misaligned accesses instead of faulting them.
module riscv151_lsu #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_fault,
    output logic [XLEN-1:0]     dcache_addr,
    output logic                dcache_re,
    output logic [XLEN/8-1:0]   dcache_we,
    output logic [XLEN-1:0]     dcache_din,
    input  logic [XLEN-1:0]     dcache_dout,
    input  logic                stall
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int SW    = OFFW + 2;

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, WAIT, DONE} state_t;
    state_t state, state_next;

    logic            we_q, uns_q, fault_q, cross_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, beat0_q, beat1_q;

    logic [OFFW-1:0] off_in;
    logic [SW-1:0]   nb_in, end_in;
    logic            illegal_in, cross_in, fault_in;

    always_comb begin
        off_in     = req_addr[OFFW-1:0];
        nb_in      = SW'(1) << req_size;
        end_in     = SW'(off_in) + nb_in;
        cross_in   = end_in > SW'(BYTES);
        illegal_in = (XLEN == 32) && (req_size == 2'd3);
`ifdef RISCV151_LSU_MISALIGN_SPLIT_EN
        fault_in   = illegal_in;
`else
        fault_in   = illegal_in || ((SW'(off_in) & (nb_in - SW'(1))) != '0);
`endif
    end

    logic [OFFW-1:0]    off_q;
    logic [SW-1:0]      nb_q;
    logic [2*BYTES-1:0] mask;
    logic [2*XLEN-1:0]  shifted, cat;
    logic [XLEN-1:0]    word_addr, rlow, merged;
    logic               sign_bit;

    // Both beats are views of a double-width window starting at the word address.
    always_comb begin
        off_q     = addr_q[OFFW-1:0];
        nb_q      = SW'(1) << size_q;
        mask      = (((2*BYTES)'(1) << nb_q) - (2*BYTES)'(1)) << off_q;
        shifted   = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
        word_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
        cat       = {beat1_q, beat0_q};
        rlow      = XLEN'(cat >> {off_q, 3'b000});
        case (size_q)
            2'd0:    sign_bit = rlow[7];
            2'd1:    sign_bit = rlow[15];
            2'd2:    sign_bit = rlow[31];
            default: sign_bit = rlow[XLEN-1];
        endcase
        merged = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(nb_q)) merged[8*i +: 8] = rlow[8*i +: 8];
            else                merged[8*i +: 8] = {8{sign_bit & ~uns_q}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            fault_q <= 1'b0;
            cross_q <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            beat1_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                fault_q <= fault_in;
                cross_q <= cross_in;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                beat0_q <= '0;
                beat1_q <= '0;
            end
            // Read data trails each accepted read beat by one unstalled cycle.
            if (state == ISSUE1 && !stall && !we_q) beat0_q <= dcache_dout;
            if (state == WAIT && !stall) begin
                if (cross_q) beat1_q <= dcache_dout;
                else         beat0_q <= dcache_dout;
            end
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_fault  = 1'b0;
        dcache_addr = '0;
        dcache_re   = 1'b0;
        dcache_we   = '0;
        dcache_din  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = fault_in ? DONE : ISSUE0;
            end
            ISSUE0: begin
                dcache_addr = word_addr;
                if (we_q) begin
                    dcache_we  = mask[BYTES-1:0];
                    dcache_din = shifted[XLEN-1:0];
                end else begin
                    dcache_re = 1'b1;
                end
                if (!stall) state_next = cross_q ? ISSUE1 : (we_q ? DONE : WAIT);
            end
            ISSUE1: begin
                dcache_addr = word_addr + XLEN'(BYTES);
                if (we_q) begin
                    dcache_we  = mask[2*BYTES-1:BYTES];
                    dcache_din = shifted[2*XLEN-1:XLEN];
                end else begin
                    dcache_re = 1'b1;
                end
                if (!stall) state_next = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (!stall) state_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = (!we_q && !fault_q) ? merged : '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (!reset) begin
            state_next  = IDLE;
            req_ready   = 1'b0;
            resp_valid  = 1'b0;
            resp_rdata  = '0;
            resp_fault  = 1'b0;
            dcache_addr = '0;
            dcache_re   = 1'b0;
            dcache_we   = '0;
            dcache_din  = '0;
        end
    end
endmodule

// File: tb/tb_riscv151_lsu.sv
// Bench for riscv151_lsu (XLEN=32): directed scenarios plus randomized requests against a byte-memory model.
module tb_riscv151_lsu;
    localparam int XLEN   = 32;
    localparam int BUDGET = 40;
`ifdef RISCV151_LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic            clk, reset, req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]      req_size;
    logic [31:0]     req_addr, req_wdata, resp_rdata, dcache_addr, dcache_din, dcache_dout;
    logic            resp_valid, resp_fault, dcache_re, stall;
    logic [3:0]      dcache_we;

    riscv151_lsu #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .dcache_addr(dcache_addr),
        .dcache_re(dcache_re), .dcache_we(dcache_we), .dcache_din(dcache_din),
        .dcache_dout(dcache_dout), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_din_q[$];
    logic [3:0]  wr_we_q[$];
    logic [31:0] exp_q[$];
    logic        cyc_re [0:BUDGET];
    logic [31:0] cyc_addr [0:BUDGET];
    int          r_cyc, both_cnt;
    logic [31:0] r_rdata;
    logic        r_fault, r_after, r_ready0;

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (!mem.exists(wa)) mem[wa] = $urandom;
        return mem[wa];
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return w[8*int'(a[1:0]) +: 8];
    endfunction

    // Little-endian read of the request's bytes from the model memory, then extension.
    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
        logic [31:0] v;
        logic [7:0]  b;
        int n;
        n = 1 << size;
        v = '0;
        b = '0;
        for (int k = 0; k < n; k++) begin
            b = byte_at(a + 32'(k));
            v[8*k +: 8] = b;
        end
        if (!uns && b[7]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic exp_fault(input logic [31:0] a, input logic [1:0] size);
        int n;
        n = 1 << size;
        return (size == 2'd3) || (!SPLIT && ((int'(a[1:0]) % n) != 0));
    endfunction

    function automatic logic exp_cross(input logic [31:0] a, input logic [1:0] size);
        return (int'(a[1:0]) + (1 << size)) > 4;
    endfunction

    // Response cycle: one cycle past the point where `need` unstalled memory cycles have elapsed.
    function automatic int exp_cycle(input int need_in, input logic [BUDGET:0] spat);
        int c, need;
        c = 1;
        need = need_in;
        while (need > 0 && c <= BUDGET) begin
            if (!spat[c]) need--;
            c++;
        end
        return c;
    endfunction

    // Store lane b*4+j carries wdata byte (b*4+j-off) when that byte is part of the access.
    function automatic logic [35:0] exp_store_beat(input logic [31:0] a, input logic [1:0] size,
                                                   input logic [31:0] wd, input int b);
        logic [3:0]  we;
        logic [31:0] din;
        int idx;
        we = '0;
        din = '0;
        for (int j = 0; j < 4; j++) begin
            idx = b*4 + j - int'(a[1:0]);
            if (idx >= 0 && idx < 4) din[8*j +: 8] = wd[8*idx +: 8];
            if (idx >= 0 && idx < (1 << size)) we[j] = 1'b1;
        end
        return {we, din};
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [BUDGET:0] spat);
        logic        pend, fin;
        logic [31:0] pend_data;
        int c;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; stall = spat[0]; dcache_dout = $urandom;
        rd_addr_q.delete(); wr_addr_q.delete(); wr_din_q.delete(); wr_we_q.delete();
        for (int i = 0; i <= BUDGET; i++) begin cyc_re[i] = 1'b0; cyc_addr[i] = '0; end
        both_cnt = 0; r_cyc = -1; r_rdata = '0; r_fault = 1'b0;
        pend = 1'b0; pend_data = '0; fin = 1'b0; c = 0;
        #1;
        r_ready0 = req_ready;
        while (!fin && c < BUDGET) begin
            @(negedge clk);
            c++;
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
            req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
            if (pend) begin dcache_dout = pend_data; pend = 1'b0; end
            stall = spat[c];
            #1;
            cyc_re[c] = dcache_re;
            cyc_addr[c] = dcache_addr;
            if (dcache_re && dcache_we != '0) both_cnt++;
            if (dcache_re && !stall) begin
                rd_addr_q.push_back(dcache_addr);
                pend = 1'b1;
                pend_data = mem_word(dcache_addr);
            end
            if (dcache_we != '0 && !stall) begin
                wr_addr_q.push_back(dcache_addr);
                wr_we_q.push_back(dcache_we);
                wr_din_q.push_back(dcache_din);
            end
            if (resp_valid) begin
                r_cyc = c; r_rdata = resp_rdata; r_fault = resp_fault; fin = 1'b1;
            end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        r_after = resp_valid;
    endtask

    task automatic test_reset;
        reset = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h12345678; stall = 1'b0; dcache_dout = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({req_ready, resp_valid, resp_rdata, resp_fault, dcache_re, dcache_we, dcache_din, dcache_addr} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: ready=%b rv=%b rdata=%h flt=%b re=%b we=%b din=%h addr=%h expected all 0",
                         i, req_ready, resp_valid, resp_rdata, resp_fault, dcache_re, dcache_we, dcache_din, dcache_addr);
            end
        end
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_aligned_load;
        logic [BUDGET:0] spat;
        spat = '0;
        mem[32'h100] = 32'hDEADBEEF;
        drive_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, spat);
        checks++;
        if (r_ready0 !== 1'b1) begin failures++; $display("FAIL lw_ready: got %b expected 1", r_ready0); end
        checks++;
        if (cyc_re[1] !== 1'b1 || cyc_addr[1] !== 32'h100) begin
            failures++; $display("FAIL lw_c1_beat: re=%b addr=%h expected re=1 addr=00000100", cyc_re[1], cyc_addr[1]);
        end
        checks++;
        if (r_cyc !== 3) begin failures++; $display("FAIL lw_latency: got %0d expected 3", r_cyc); end
        checks++;
        if (r_rdata !== 32'hDEADBEEF || r_fault !== 1'b0) begin
            failures++; $display("FAIL lw_data: got %h flt=%b expected deadbeef flt=0", r_rdata, r_fault);
        end
        checks++;
        if (r_after !== 1'b0) begin failures++; $display("FAIL lw_resp_pulse: resp_valid=%b after DONE expected 0", r_after); end
    endtask

    task automatic test_byte_load;
        logic [BUDGET:0] spat;
        spat = '0;
        mem[32'h100] = 32'h80112233;
        drive_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, spat);
        checks++;
        if (r_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sign: got %h expected ffffff80", r_rdata); end
        drive_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, spat);
        checks++;
        if (r_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_zero: got %h expected 00000080", r_rdata); end
    endtask

    task automatic test_half_store;
        logic [BUDGET:0] spat;
        spat = '0;
        drive_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, spat);
        checks++;
        if (wr_addr_q.size() != 1 || rd_addr_q.size() != 0) begin
            failures++; $display("FAIL sh_beats: writes=%0d reads=%0d expected 1/0", wr_addr_q.size(), rd_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== 32'h100 || wr_we_q[0] !== 4'b1100 || wr_din_q[0] !== 32'hABCD0000) begin
                failures++; $display("FAIL sh_beat0: addr=%h we=%b din=%h expected 00000100 1100 abcd0000",
                                     wr_addr_q[0], wr_we_q[0], wr_din_q[0]);
            end
        end
        checks++;
        if (r_cyc !== 2 || r_rdata !== 32'h0) begin failures++; $display("FAIL sh_resp: cyc=%0d rdata=%h expected 2 0", r_cyc, r_rdata); end
    endtask

    task automatic test_split;
        logic [BUDGET:0] spat;
        spat = '0;
        mem[32'h0FC] = 32'h44332211;
        mem[32'h100] = 32'h88776655;
        drive_req(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, spat);
        if (SPLIT) begin
            checks++;
            if (rd_addr_q.size() != 2 || r_cyc !== 4 || r_rdata !== 32'h66554433) begin
                failures++; $display("FAIL split_lw: reads=%0d cyc=%0d rdata=%h expected 2 4 66554433", rd_addr_q.size(), r_cyc, r_rdata);
            end else begin
                checks++;
                if (rd_addr_q[0] !== 32'h0FC || rd_addr_q[1] !== 32'h100) begin
                    failures++; $display("FAIL split_lw_addr: %h %h expected 000000fc 00000100", rd_addr_q[0], rd_addr_q[1]);
                end
            end
        end else begin
            checks++;
            if (rd_addr_q.size() != 0 || r_cyc !== 1 || r_fault !== 1'b1 || r_rdata !== 32'h0) begin
                failures++; $display("FAIL misalign_lw_fault: reads=%0d cyc=%0d flt=%b rdata=%h expected 0 1 1 0", rd_addr_q.size(), r_cyc, r_fault, r_rdata);
            end
        end
        drive_req(1'b1, 2'd2, 1'b0, 32'h0FF, 32'hAABBCCDD, spat);
        if (SPLIT) begin
            checks++;
            if (wr_addr_q.size() != 2 || r_cyc !== 3) begin
                failures++; $display("FAIL split_sw: writes=%0d cyc=%0d expected 2 3", wr_addr_q.size(), r_cyc);
            end else begin
                checks++;
                if (wr_addr_q[0] !== 32'h0FC || wr_we_q[0] !== 4'b1000 || wr_din_q[0] !== 32'hDD000000 ||
                    wr_addr_q[1] !== 32'h100 || wr_we_q[1] !== 4'b0111 || wr_din_q[1] !== 32'h00AABBCC) begin
                    failures++; $display("FAIL split_sw_beats: %h/%b/%h %h/%b/%h expected fc/1000/dd000000 100/0111/00aabbcc",
                                         wr_addr_q[0], wr_we_q[0], wr_din_q[0], wr_addr_q[1], wr_we_q[1], wr_din_q[1]);
                end
            end
        end else begin
            checks++;
            if (wr_addr_q.size() != 0 || r_cyc !== 1 || r_fault !== 1'b1) begin
                failures++; $display("FAIL misalign_sw_fault: writes=%0d cyc=%0d flt=%b expected 0 1 1", wr_addr_q.size(), r_cyc, r_fault);
            end
        end
    endtask

    task automatic test_stall_load;
        logic [BUDGET:0] spat;
        spat = '0;
        spat[1] = 1'b1;
        spat[2] = 1'b1;
        mem[32'h200] = 32'h5A6B7C8D;
        drive_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, spat);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (cyc_re[c] !== 1'b1 || cyc_addr[c] !== 32'h200) begin
                failures++; $display("FAIL stall_hold c%0d: re=%b addr=%h expected 1 00000200", c, cyc_re[c], cyc_addr[c]);
            end
        end
        checks++;
        if (r_cyc !== 5 || r_rdata !== 32'h5A6B7C8D) begin
            failures++; $display("FAIL stall_resp: cyc=%0d rdata=%h expected 5 5a6b7c8d", r_cyc, r_rdata);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = SPLIT ? 32'h0FE : 32'h300; stall = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (dcache_re !== 1'b1) begin failures++; $display("FAIL rstmid_issue0: re=%b expected 1", dcache_re); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_fault, dcache_re, dcache_we, dcache_din, dcache_addr} !== '0) begin
            failures++; $display("FAIL rstmid_outputs: ready=%b rv=%b re=%b we=%b addr=%h expected all 0",
                                 req_ready, resp_valid, dcache_re, dcache_we, dcache_addr);
        end
        repeat (2) begin @(negedge clk); #1; if (resp_valid) seen++; end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
        repeat (5) begin @(negedge clk); #1; if (resp_valid) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL rstmid_no_resp: resp_valid seen %0d times expected 0", seen); end
    endtask

    task automatic test_fault;
        logic [BUDGET:0] spat;
        spat = '0;
        drive_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, spat);
        checks++;
        if (r_cyc !== 1 || r_fault !== 1'b1 || r_rdata !== 32'h0 || rd_addr_q.size() != 0 || wr_addr_q.size() != 0) begin
            failures++; $display("FAIL ld_illegal: cyc=%0d flt=%b rdata=%h reads=%0d writes=%0d expected 1 1 0 0 0",
                                 r_cyc, r_fault, r_rdata, rd_addr_q.size(), wr_addr_q.size());
        end
        drive_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, spat);
        checks++;
        if (r_fault !== !SPLIT || r_cyc !== (SPLIT ? 4 : 1) || (!SPLIT && rd_addr_q.size() != 0)) begin
            failures++; $display("FAIL lw_0x102: flt=%b cyc=%0d reads=%0d expected flt=%b", r_fault, r_cyc, rd_addr_q.size(), !SPLIT);
        end
    endtask

    task automatic test_random;
        logic [BUDGET:0] spat;
        logic [31:0] a, wd, er;
        logic [1:0]  sz;
        logic        we, uns, ef, ec;
        logic [35:0] sb;
        int nbeats, ecyc;
        for (int it = 0; it < 80; it++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a = 32'h400 + 32'($urandom_range(0, 63));
            wd = $urandom;
            spat = '0;
            for (int i = 1; i <= 20; i++) spat[i] = ($urandom_range(0, 3) == 0);
            ef = exp_fault(a, sz);
            ec = exp_cross(a, sz);
            nbeats = ef ? 0 : (ec ? 2 : 1);
            ecyc = exp_cycle(ef ? 0 : (we ? nbeats : nbeats + 1), spat);
            drive_req(we, sz, uns, a, wd, spat);
            er = (we || ef) ? 32'h0 : exp_load(a, sz, uns);
            checks++;
            if (r_cyc !== ecyc || r_fault !== ef || r_rdata !== er) begin
                failures++; $display("FAIL rand_resp it%0d we=%b sz=%0d a=%h: cyc=%0d flt=%b rdata=%h expected %0d %b %h",
                                     it, we, sz, a, r_cyc, r_fault, r_rdata, ecyc, ef, er);
            end
            exp_q.delete();
            for (int b = 0; b < nbeats; b++) exp_q.push_back({a[31:2], 2'b00} + 32'(4*b));
            checks++;
            if ((we ? wr_addr_q.size() : rd_addr_q.size()) != exp_q.size() || (we ? rd_addr_q.size() : wr_addr_q.size()) != 0) begin
                failures++; $display("FAIL rand_beats it%0d: reads=%0d writes=%0d expected %0d", it, rd_addr_q.size(), wr_addr_q.size(), exp_q.size());
            end else begin
                for (int b = 0; b < nbeats; b++) begin
                    sb = exp_store_beat(a, sz, wd, b);
                    checks++;
                    if (we ? (wr_addr_q[b] !== exp_q[b] || wr_we_q[b] !== sb[35:32] || wr_din_q[b] !== sb[31:0])
                           : (rd_addr_q[b] !== exp_q[b])) begin
                        failures++; $display("FAIL rand_beat it%0d b%0d: addr=%h expected %h (store we/din expected %b/%h)",
                                             it, b, we ? wr_addr_q[b] : rd_addr_q[b], exp_q[b], sb[35:32], sb[31:0]);
                    end
                end
            end
            checks++;
            if (both_cnt != 0 || r_after !== 1'b0) begin
                failures++; $display("FAIL rand_protocol it%0d: re_we_overlap=%0d resp_after=%b expected 0 0", it, both_cnt, r_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_byte_load();
        test_half_store();
        test_split();
        test_stall_load();
        test_reset_mid();
        test_fault();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv151_lsu.md
Name: riscv151_lsu

Overview:
Parametrised load/store unit for the Riscv151 memory stage. It replaces the fixed single-beat store-mask and load-mask logic with an FSM-driven unit, generic in XLEN. Each request is accepted by a valid/ready handshake and issued as one or two aligned dcache beats. It honours the dcache `stall` input and returns sign- or zero-extended load data with a completion pulse.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64. BYTES = XLEN/8 and OFFW = log2(BYTES) are derived.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when XLEN=64).
req_unsigned  in  1  zero-extend the load result (LBU/LHU/LWU).
req_addr  in  XLEN  byte address.
req_wdata  in  XLEN  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
resp_fault  out  1  request rejected; valid only with resp_valid.
dcache_addr  out  XLEN  beat address, with the low OFFW bits forced to 0.
dcache_re  out  1  read beat.
dcache_we  out  BYTES  byte-lane write enables.
dcache_din  out  XLEN  lane-aligned write data.
dcache_dout  in  XLEN  read data, valid in the first non-stalled cycle after the read beat is accepted.
stall  in  1  memory busy.

Behaviour:
- Reset (reset=0 at a clock edge): state = IDLE. While reset is low, req_ready=0, and resp_valid, resp_rdata, resp_fault, dcache_re, dcache_we, dcache_din and dcache_addr are all 0. Reset mid-operation abandons the request with no response.
- States: IDLE, ISSUE0, ISSUE1, WAIT, DONE.
- IDLE: req_ready=1. A request is accepted when req_valid=1, and all req_* inputs are latched.
  - off = addr[OFFW-1:0]; nb = 1 << size.
  - The request crosses a word boundary when off + nb > BYTES.
  - Illegal size (size 3 with XLEN=32) gives a fault.
  - Next state is DONE on a fault, otherwise ISSUE0.
- ISSUE0: drive beat 0 at the word address of req_addr.
  - Store: byte mask m = ((1<<nb)-1) << off, computed over 2*BYTES lanes. shifted = wdata << (8*off), computed over 2*XLEN bits. Beat 0 drives dcache_we = m[BYTES-1:0] and dcache_din = shifted[XLEN-1:0].
  - Load: dcache_re=1.
  - Next state is ISSUE1 if the request crosses, else WAIT (load) or DONE (store).
- ISSUE1: drive beat 1 at the word address + BYTES.
  - Store: dcache_we = m[2*BYTES-1:BYTES], dcache_din = shifted[2*XLEN-1:XLEN].
  - Load: capture dcache_dout as the beat-0 word; dcache_re=1.
  - Next state is WAIT (load) or DONE (store).
- WAIT (loads only): capture dcache_dout as the last beat's word; next state is DONE.
- DONE: resp_valid=1 for exactly one cycle; next state is IDLE. req_ready is 0 in every state except IDLE.
- Load merge:
  - cat = {beat1, beat0}; beat1 = 0 if the request did not cross.
  - r = cat >> (8*off); take the low nb bytes of r.
  - Sign-extend from the top byte taken, or zero-extend if req_unsigned=1.
- Stall: while stall=1 in ISSUE0, ISSUE1 or WAIT, the FSM, the captures and all dcache outputs hold. A beat is accepted only in a cycle with stall=0. stall has no effect in IDLE or DONE.
- Latency with no stall, counting the accept cycle as c0:
  - Aligned load: resp_valid in c3.
  - Crossing load: resp_valid in c4.
  - Aligned store: resp_valid in c2.
  - Crossing store: resp_valid in c3.
  - Fault: resp_valid in c1.
  - Each stalled cycle adds exactly one cycle.
- dcache_re and dcache_we are 0 outside ISSUE0/ISSUE1. dcache_re and dcache_we are never asserted in the same cycle.

Optional Feature:
RISCV151_LSU_MISALIGN_SPLIT_EN
- Defined: misaligned requests (off % nb != 0) are serviced, using two beats when the access crosses a word boundary. resp_fault is asserted only for illegal sizes.
- Undefined: any misaligned request faults. It goes IDLE -> DONE with resp_fault=1, no dcache_re/dcache_we activity, and resp_rdata=0. ISSUE1 is unreachable and may be optimised away.

Test Plan:
1. Aligned load, XLEN=32: LW 0x100, dout=0xDEADBEEF -> c1 re=1, addr=0x100; c3 resp_valid=1, rdata=0xDEADBEEF, fault=0.
2. Byte load at 0x103 with dout=0x80112233: LB -> rdata=0xFFFFFF80; LBU -> rdata=0x00000080.
3. Half store: SH 0x102, wdata=0x0000ABCD -> c1 we=4'b1100, din=0xABCD0000, addr=0x100; c2 resp_valid=1.
4. Split accesses (EN defined):
   - LW 0x0FE: beat 0 addr 0xFC returns dout 0x44332211; beat 1 addr 0x100 returns dout 0x88776655 -> c4 rdata=0x66554433.
   - SW 0x0FF, wdata=0xAABBCCDD: beat 0 addr 0xFC, we=4'b1000, din=0xDD000000; beat 1 addr 0x100, we=4'b0111, din=0x00AABBCC.
5. Stall during aligned load: stall=1 in c1 and c2 of an aligned LW -> addr/re held through c3; resp_valid in c5 with correct data. Separately, reset=0 in the cycle after the ISSUE0 beat of a split LW -> no resp_valid; req_ready=1 in the first cycle after reset=1.
6. Misaligned fault (EN undefined): LW 0x102 -> no re/we in any cycle; c1 resp_valid=1, resp_fault=1, rdata=0. Also LD (size 3) at XLEN=32 -> fault in both builds.
